// File: rtl/stage_if_pkg.sv
// Shared fetch-stage definitions: bus widths, fetch FSM encoding, default reset PC.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package stage_if_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    typedef logic [INST_ADDR_W-1:0] inst_addr_t;
    typedef logic [INST_W-1:0]      inst_t;

    localparam inst_addr_t RESET_PC_DEF = 32'h0000_0000;

    // FS_HALT is only reachable when the misaligned-target trap is built in.
    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_DROP = 2'd2,
        FS_HALT = 2'd3
    } fetch_state_e;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        inst_addr_t pc;
        inst_t      inst;
    } fetch_pkt_t;

    // Sequential fetch step; wraps modulo 2^32 by construction.
    function automatic inst_addr_t pc_next(input inst_addr_t pc);
        return pc + 32'd4;
    endfunction

    // Forces a redirect target onto a word boundary.
    function automatic inst_addr_t align_word(input inst_addr_t a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/stage_if_if.sv
// Bundles the fetch stage's memory read port and its IF/ID / decode-feedback signals.
// Latency: n/a (wires only).
// Backpressure: mem_req held until mem_ack; decode holds off the IF/ID register with id_stall.
//
// Modports:
//   master - the fetch stage (drives mem_req/mem_addr, id_valid/id_pc/id_inst, fetch_misalign)
//   slave  - the environment: instruction memory plus decode stage
interface stage_if_if;
    import stage_if_pkg::*;

    // memory read port
    logic       mem_req;
    inst_addr_t mem_addr;
    logic       mem_ack;
    inst_t      mem_rdata;

    // IF/ID register towards decode
    logic       id_valid;
    inst_addr_t id_pc;
    inst_t      id_inst;

    // decode feedback
    logic       id_stall;
    logic       id_br;
    inst_addr_t id_br_addr;

    // sticky misaligned-redirect flag
    logic       fetch_misalign;

    modport master (
        output mem_req, mem_addr,
        input  mem_ack, mem_rdata,
        output id_valid, id_pc, id_inst,
        input  id_stall, id_br, id_br_addr,
        output fetch_misalign
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_ack, mem_rdata,
        input  id_valid, id_pc, id_inst,
        output id_stall, id_br, id_br_addr,
        input  fetch_misalign
    );

endinterface

// File: rtl/stage_if_fetch_skid_buf.sv
// One-entry {pc, inst} holding register that catches a fetch landing while decode is stalled.
// Latency: load visible on vld/dat one cycle after the load edge.
// Backpressure: none internally; the owner never loads while full unless it also unloads.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   load, load_dat    capture a packet (wins over unload in the same cycle)
//   unload            entry is being moved out this cycle
//   flush             discard the entry (wins over everything)
//   vld, dat          current occupancy and contents
module fetch_skid_buf
    import stage_if_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  fetch_pkt_t load_dat,
    input  logic       unload,
    input  logic       flush,
    output logic       vld,
    output fetch_pkt_t dat
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld <= 1'b0;
            dat <= '0;
        end else begin
            if (flush)
                vld <= 1'b0;
            else if (load)
                vld <= 1'b1;      // load+unload together: old entry leaves, new one stays
            else if (unload)
                vld <= 1'b0;

            if (load && !flush)
                dat <= load_dat;
        end
    end

endmodule

// File: rtl/stage_if.sv
// Instruction-fetch stage: owns fetch PC, one-outstanding memory reads, IF/ID register with skid.
// Latency: ack in cycle t -> id_valid in t+1; zero-wait memory sustains one instruction per cycle.
// Backpressure: id_stall holds IF/ID; one landing fetch parks in the skid, then requests pause.
//
// Ports:
//   clk, rst   clock (rising edge), asynchronous active-low reset
//   bus        stage_if_if.master: mem_req/mem_addr/mem_ack/mem_rdata read port,
//              id_valid/id_pc/id_inst IF/ID register, id_stall/id_br/id_br_addr from decode,
//              fetch_misalign sticky flag
// Parameter RESET_PC: first fetch address after reset.
// Build option FETCH_MISALIGN_TRAP_EN: a redirect to a non-word-aligned target sets the sticky
// fetch_misalign flag and parks the fetcher in HALT. Without it, targets are forced to word
// alignment and fetch_misalign is tied low.
module stage_if
    import stage_if_pkg::*;
#(
    parameter inst_addr_t RESET_PC = RESET_PC_DEF
)(
    input  logic        clk,
    input  logic        rst,
    stage_if_if.master  bus
);

    fetch_state_e state_q, state_d;
    inst_addr_t   fetch_pc_q, fetch_pc_d;
    inst_addr_t   drop_addr_q, drop_addr_d;

    logic         id_vld_q;
    fetch_pkt_t   id_q;

    logic         skid_vld;
    fetch_pkt_t   skid_dat;

    logic         consume;
    logic         redirect;
    inst_addr_t   br_target;
    logic         deliver;
    logic         to_id;
    logic         to_skid;
    logic         skid_unload;
    logic         skid_occ_nxt;
    fetch_pkt_t   fetch_pkt;

    // ------------------------------------------------------------------
    // Decode-side handshake. A branch is only honoured when decode really
    // takes the instruction, so id_br during a stall waits for the stall
    // to clear.
    // ------------------------------------------------------------------
    assign consume  = id_vld_q && !bus.id_stall;
    assign redirect = consume && bus.id_br;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
    logic br_misalign;

    assign br_misalign = redirect && (bus.id_br_addr[1:0] != 2'b00);
    assign br_target   = bus.id_br_addr;
`else
    assign br_target   = align_word(bus.id_br_addr);
`endif

    // ------------------------------------------------------------------
    // Delivery routing. Only a REQ-state ack carries a live word; DROP acks
    // and acks coinciding with a redirect are wrong-path and thrown away.
    // The skid is only used when IF/ID stays occupied or the skid already
    // holds an older word that must leave first.
    // ------------------------------------------------------------------
    assign deliver     = (state_q == FS_REQ) && bus.mem_ack && !redirect;
    assign to_id       = deliver && (!id_vld_q || consume) && !skid_vld;
    assign to_skid     = deliver && !to_id;
    assign skid_unload = consume && skid_vld;
    assign fetch_pkt   = '{pc: fetch_pc_q, inst: bus.mem_rdata};

    // Skid occupancy after this edge; decides whether REQ must pause.
    assign skid_occ_nxt = !redirect && (to_skid || (skid_vld && !consume));

    fetch_skid_buf u_skid (
        .clk      (clk),
        .rst      (rst),
        .load     (to_skid),
        .load_dat (fetch_pkt),
        .unload   (skid_unload),
        .flush    (redirect),
        .vld      (skid_vld),
        .dat      (skid_dat)
    );

    // ------------------------------------------------------------------
    // Fetch FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FS_IDLE;
            fetch_pc_q  <= RESET_PC;
            drop_addr_q <= RESET_PC;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            drop_addr_q <= drop_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        drop_addr_d = drop_addr_q;

        case (state_q)
            FS_IDLE: begin
                if (redirect) begin
                    fetch_pc_d = br_target;
                    state_d    = FS_REQ;
                end else if (!skid_vld) begin
                    state_d    = FS_REQ;
                end
            end

            FS_REQ: begin
                if (redirect) begin
                    fetch_pc_d = br_target;
                    if (!bus.mem_ack) begin
                        // the squashed read is still outstanding; keep presenting
                        // its address until the memory completes it
                        drop_addr_d = fetch_pc_q;
                        state_d     = FS_DROP;
                    end
                end else if (bus.mem_ack) begin
                    fetch_pc_d = pc_next(fetch_pc_q);
                    state_d    = skid_occ_nxt ? FS_IDLE : FS_REQ;
                end
            end

            FS_DROP: begin
                if (redirect)
                    fetch_pc_d = br_target;
                if (bus.mem_ack)
                    state_d = FS_REQ;
            end

            FS_HALT: begin
                state_d = FS_HALT;
            end

            default: begin
                state_d = FS_IDLE;
            end
        endcase

`ifdef FETCH_MISALIGN_TRAP_EN
        // Once the flag is up, any path that would start a new fetch parks
        // instead; a pending DROP still completes its read first.
        if (misalign_d && (state_d == FS_REQ))
            state_d = FS_HALT;
`endif
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_comb begin
        misalign_d = misalign_q;
        if (br_misalign)
            misalign_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            misalign_q <= 1'b0;
        else
            misalign_q <= misalign_d;
    end

    assign bus.fetch_misalign = misalign_q;
`else
    assign bus.fetch_misalign = 1'b0;
`endif

    // Request outputs come straight from state so reset drops mem_req at once.
    assign bus.mem_req  = (state_q == FS_REQ) || (state_q == FS_DROP);
    assign bus.mem_addr = (state_q == FS_DROP) ? drop_addr_q : fetch_pc_q;

    // ------------------------------------------------------------------
    // IF/ID register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_vld_q <= 1'b0;
            id_q     <= '0;
        end else if (redirect) begin
            id_vld_q <= 1'b0;
        end else if (to_id) begin
            id_vld_q <= 1'b1;
            id_q     <= fetch_pkt;
        end else if (skid_unload) begin
            id_vld_q <= 1'b1;
            id_q     <= skid_dat;
        end else if (consume) begin
            id_vld_q <= 1'b0;
        end
    end

    assign bus.id_valid = id_vld_q;
    assign bus.id_pc    = id_q.pc;
    assign bus.id_inst  = id_q.inst;

endmodule

// File: tb/tb_stage_if.sv
// Bench for stage_if: vector table, directed corner sequences, randomized scoreboard run.
// Latency: n/a.
// Backpressure: bench memory answers after a configurable or random wait.
`timescale 1ns/1ps
module tb_stage_if;
    import stage_if_pkg::*;

    localparam inst_addr_t RPC = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    stage_if_if bus ();

    stage_if #(.RESET_PC(RPC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // memory model state
    bit         busy      = 1'b0;
    int         wait_left = 0;
    int         mem_wait  = 0;     // <0 selects a random 0..3 wait per request
    inst_addr_t held_addr = '0;

    typedef struct {
        logic       stall;
        logic       br;
        inst_addr_t br_addr;
        logic       e_req;
        inst_addr_t e_addr;
        logic       e_vld;
        inst_addr_t e_pc;
    } vec_t;

    vec_t tbl[16];

    function automatic inst_t inst_of(input inst_addr_t a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic vec_t mk(input logic s, input logic b, input inst_addr_t ba,
                                input logic rq, input inst_addr_t ad,
                                input logic v, input inst_addr_t pc);
        vec_t r;
        r.stall = s; r.br = b; r.br_addr = ba;
        r.e_req = rq; r.e_addr = ad; r.e_vld = v; r.e_pc = pc;
        return r;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        check1 ({tag, " mem_req"},        bus.mem_req,        1'b0);
        check32({tag, " mem_addr"},       bus.mem_addr,       RPC);
        check1 ({tag, " id_valid"},       bus.id_valid,       1'b0);
        check32({tag, " id_pc"},          bus.id_pc,          32'h0);
        check32({tag, " id_inst"},        bus.id_inst,        32'h0);
        check1 ({tag, " fetch_misalign"}, bus.fetch_misalign, 1'b0);
    endtask

    // Called once per cycle just after the falling edge: applies decode
    // inputs and plays the memory side for this cycle.
    task automatic drive(input logic stall, input logic br, input inst_addr_t br_addr);
        bus.id_stall   = stall;
        bus.id_br      = br;
        bus.id_br_addr = br_addr;
        if (bus.mem_req) begin
            if (!busy) begin
                busy      = 1'b1;
                wait_left = (mem_wait < 0) ? int'($urandom_range(0, 3)) : mem_wait;
                held_addr = bus.mem_addr;
            end else begin
                check32("mem_addr stable", bus.mem_addr, held_addr);
            end
            if (wait_left == 0) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = inst_of(bus.mem_addr);
                busy          = 1'b0;
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = 32'hDEAD_BEEF;
                wait_left--;
            end
        end else begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 32'hDEAD_BEEF;
            busy          = 1'b0;
        end
    endtask

    task automatic do_reset(input string tag);
        rst            = 1'b0;
        busy           = 1'b0;
        bus.mem_ack    = 1'b0;
        bus.mem_rdata  = '0;
        bus.id_stall   = 1'b0;
        bus.id_br      = 1'b0;
        bus.id_br_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset(tag);
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         found;
        bit         seen_req;
        int         n_cons;
        inst_addr_t exp_pc;
        inst_addr_t tgt;
        logic       st, br;

        // Zero-wait memory, RESET_PC=0x100. Columns: stall, br, br_addr |
        // expected mem_req, mem_addr, id_valid, id_pc (pc checked when valid).
        tbl[0]  = mk(0, 0, 32'h0,   0, 32'h100, 0, 32'h0);
        tbl[1]  = mk(0, 0, 32'h0,   1, 32'h100, 0, 32'h0);
        tbl[2]  = mk(0, 0, 32'h0,   1, 32'h104, 1, 32'h100);
        tbl[3]  = mk(1, 0, 32'h0,   1, 32'h108, 1, 32'h104);   // ack lands while stalled
        tbl[4]  = mk(1, 1, 32'h300, 0, 32'h10C, 1, 32'h104);   // branch ignored under stall
        tbl[5]  = mk(1, 0, 32'h0,   0, 32'h10C, 1, 32'h104);
        tbl[6]  = mk(0, 0, 32'h0,   0, 32'h10C, 1, 32'h104);
        tbl[7]  = mk(0, 0, 32'h0,   0, 32'h10C, 1, 32'h108);   // skid word emerges
        tbl[8]  = mk(0, 0, 32'h0,   1, 32'h10C, 0, 32'h0);
        tbl[9]  = mk(0, 1, 32'h200, 1, 32'h110, 1, 32'h10C);   // redirect, same-cycle ack dropped
        tbl[10] = mk(0, 0, 32'h0,   1, 32'h200, 0, 32'h0);
        tbl[11] = mk(0, 0, 32'h0,   1, 32'h204, 1, 32'h200);
        tbl[12] = mk(1, 1, 32'h400, 1, 32'h208, 1, 32'h204);   // stalled branch, word parks
        tbl[13] = mk(0, 1, 32'h500, 0, 32'h20C, 1, 32'h204);   // branch honoured once unstalled
        tbl[14] = mk(0, 0, 32'h0,   1, 32'h500, 0, 32'h0);
        tbl[15] = mk(0, 0, 32'h0,   1, 32'h504, 1, 32'h500);

        // ---------------- vector table ----------------
        mem_wait = 0;
        do_reset("reset0");
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(tbl[i].stall, tbl[i].br, tbl[i].br_addr);
            check1 ($sformatf("vec%0d mem_req", i),  bus.mem_req,  tbl[i].e_req);
            check32($sformatf("vec%0d mem_addr", i), bus.mem_addr, tbl[i].e_addr);
            check1 ($sformatf("vec%0d id_valid", i), bus.id_valid, tbl[i].e_vld);
            if (tbl[i].e_vld) begin
                check32($sformatf("vec%0d id_pc", i),   bus.id_pc,   tbl[i].e_pc);
                check32($sformatf("vec%0d id_inst", i), bus.id_inst, inst_of(tbl[i].e_pc));
            end
        end

        // ---------------- misaligned redirect to 0x202 ----------------
        mem_wait = 0;
        do_reset("reset1");
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (bus.id_valid) begin
                found = 1'b1;
                drive(1'b0, 1'b1, 32'h202);
            end else begin
                drive(1'b0, 1'b0, 32'h0);
            end
        end
        check1("mis first id_valid", found, 1'b1);
`ifdef FETCH_MISALIGN_TRAP_EN
        repeat (3) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 32'h0);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 32'h0);
            check1("mis flag",     bus.fetch_misalign, 1'b1);
            check1("mis id_valid", bus.id_valid,       1'b0);
            check1("mis mem_req",  bus.mem_req,        1'b0);
        end
`else
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 32'h0);
            check1("mis flag", bus.fetch_misalign, 1'b0);
            if (bus.id_valid) begin
                found = 1'b1;
                check32("mis aligned pc", bus.id_pc, 32'h200);
            end
        end
        check1("mis target arrives", found, 1'b1);
`endif

        // ---------------- redirect while a slow read is in flight ----------------
        mem_wait = 2;
        do_reset("reset2");
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (bus.id_valid && bus.id_pc == 32'h104) begin
                found = 1'b1;
                check1 ("inflight mem_req",  bus.mem_req,  1'b1);
                check32("inflight mem_addr", bus.mem_addr, 32'h108);
                drive(1'b0, 1'b1, 32'h200);
            end else begin
                drive(1'b0, 1'b0, 32'h0);
            end
        end
        check1("inflight reached 0x104", found, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 32'h0);
            if (bus.mem_req && bus.mem_addr != 32'h108) begin
                found = 1'b1;
                check32("next request after drop", bus.mem_addr, 32'h200);
            end else begin
                check1("drop id_valid", bus.id_valid, 1'b0);
            end
        end
        check1("drop completes", found, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus.id_valid) begin
                found = 1'b1;
                check32("drop next id_pc",   bus.id_pc,   32'h200);
                check32("drop next id_inst", bus.id_inst, inst_of(32'h200));
                drive(1'b1, 1'b0, 32'h0);      // hold it for the reset test
            end else begin
                drive(1'b0, 1'b0, 32'h0);
            end
        end
        check1("target delivered", found, 1'b1);

        // ---------------- asynchronous reset mid-request ----------------
        @(posedge clk);
        #2;
        check1("pre-reset mem_req",  bus.mem_req,  1'b1);
        check1("pre-reset id_valid", bus.id_valid, 1'b1);
        rst = 1'b0;
        #1;
        chk_reset("async");
        mem_wait = 0;
        do_reset("reset3");
        found    = 1'b0;
        seen_req = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (bus.mem_req && !seen_req) begin
                seen_req = 1'b1;
                check32("restart mem_addr", bus.mem_addr, RPC);
            end
            drive(1'b0, 1'b0, 32'h0);
            if (bus.id_valid) begin
                found = 1'b1;
                check32("restart id_pc", bus.id_pc, RPC);
            end
        end
        check1("restart delivers", found, 1'b1);

        // ---------------- randomized run against an in-order stream model ----------------
        mem_wait = -1;
        do_reset("reset4");
        exp_pc = RPC;
        n_cons = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            st  = ($urandom_range(0, 3) == 0);
            br  = ($urandom_range(0, 9) == 0);
            tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_3FFC);
            drive(st, br, tgt);
            if (bus.id_valid && !st) begin
                check32("rand id_pc",   bus.id_pc,   exp_pc);
                check32("rand id_inst", bus.id_inst, inst_of(exp_pc));
                n_cons++;
                exp_pc = br ? tgt : exp_pc + 32'd4;
            end
        end
        check1("rand progress", (n_cons >= 150), 1'b1);
        check1("rand fetch_misalign", bus.fetch_misalign, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
